// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the result
// consumer, and the alu_arbiter. Master is the requester/consumer side,
// slave is the arbiter.
interface alu_arbiter_if;
    // Requester 0 (execute stage)
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_sel;
    // Requester 1 (address/branch-target unit)
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_sel;
    // Result buffer
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one 32-bit integer ALU between two requesters with round-robin
// arbitration and a single-entry registered result buffer tagged with the
// issuing requester's ID.

// Purely combinational 32-bit integer ALU.
module alu_core (
    input  logic [3:0]  sel_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        bad_sel_o
);
    logic [4:0] shamt;

    assign shamt = b_i[4:0];

    // Operation decode; undefined selects produce zero and raise bad_sel_o.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        result_o  = '0;
        bad_sel_o = 1'b0;
        case (sel_i)
            4'h1:    result_o = a_i + b_i;
            4'h2:    result_o = a_i - b_i;
            4'h3:    result_o = a_i ^ b_i;
            4'h4:    result_o = a_i | b_i;
            4'h5:    result_o = a_i & b_i;
            4'h6:    result_o = a_i << shamt;
            4'h7:    result_o = a_i >> shamt;
            4'h8:    result_o = $unsigned($signed(a_i) >>> shamt);
            4'h9:    result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            4'hA:    result_o = {31'd0, a_i < b_i};
            default: bad_sel_o = 1'b1;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter logic START_PRIO     = 1'b0,
    parameter bit   ERR_ON_BAD_SEL = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    // Result buffer occupancy; rsp_valid is exactly "state is FULL".
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        rsp_id_q;
    logic        rsp_err_q;
    logic [31:0] rsp_data_q;

    logic        can_accept;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [3:0]  op_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_data_d;
    logic        alu_bad_sel;
    logic        alu_err_d;

    // Round-robin grant: a lone requester always wins; under contention
    // the requester that was not granted last wins.
    always_comb begin
        can_accept = (state_q == EMPTY) || bus.rsp_ready;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
        end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
        end
    end

    assign bus.req0_ready = can_accept & grant0;
    assign bus.req1_ready = can_accept & grant1;
    assign accept         = bus.req0_ready | bus.req1_ready;

    // The granted requester's operands drive the single shared ALU.
    assign op_sel = grant1 ? bus.req1_sel : bus.req0_sel;
    assign op_a   = grant1 ? bus.req1_a   : bus.req0_a;
    assign op_b   = grant1 ? bus.req1_b   : bus.req0_b;

    alu_core u_alu (
        .sel_i     (op_sel),
        .a_i       (op_a),
        .b_i       (op_b),
        .result_o  (alu_data_d),
        .bad_sel_o (alu_bad_sel)
    );

    assign alu_err_d = alu_bad_sel && ERR_ON_BAD_SEL;

    // Buffer FSM with registered response fields; an accept always
    // overwrites the buffer, which is legal because accept implies it is
    // empty or draining this cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= EMPTY;
            last_grant_q <= ~START_PRIO;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
        end else if (accept) begin
            state_q      <= FULL;
            last_grant_q <= grant1;
            rsp_id_q     <= grant1;
            rsp_err_q    <= alu_err_d;
            rsp_data_q   <= alu_data_d;
        end else if (state_q == FULL && bus.rsp_ready) begin
            state_q <= EMPTY;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule
